// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: registered two-level carry-lookahead adder (in: clk rst_n in_valid a b c_in; out: out_valid s c_out p_out g_out)
module carry_lookahead_adder #(
  parameter int WIDTH = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             p_out,
  output logic             g_out
);
  localparam int NG = WIDTH / 4;
  if (GROUP != 4 || WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_cfg
    $error("carry_lookahead_adder: WIDTH must be a positive multiple of 4 and GROUP must be 4");
  end
  logic [WIDTH-1:0] p, g, c;
  logic [NG-1:0] pg, gg;
  logic [NG:0] gc;
  logic blk_g, prod, bprod;
  logic [WIDTH-1:0] s_d, s_q;
  logic out_valid_d, out_valid_q, c_out_d, c_out_q, p_out_d, p_out_q, g_out_d, g_out_q;
  assign p = a ^ b;
  assign g = a & b;
  for (genvar i = 0; i < NG; i++) begin : grp
    logic [3:0] pl, gl;
    assign pl = p[4*i +: 4];
    assign gl = g[4*i +: 4];
    assign c[4*i]   = gc[i];
    assign c[4*i+1] = gl[0] | pl[0] & gc[i];
    assign c[4*i+2] = gl[1] | pl[1] & gl[0] | pl[1] & pl[0] & gc[i];
    assign c[4*i+3] = gl[2] | pl[2] & gl[1] | pl[2] & pl[1] & gl[0] | pl[2] & pl[1] & pl[0] & gc[i];
    assign pg[i] = &pl;
    assign gg[i] = gl[3] | pl[3] & gl[2] | pl[3] & pl[2] & gl[1] | pl[3] & pl[2] & pl[1] & gl[0];
  end
  always_comb begin
    gc = '0;
    prod = 1'b0;
    for (int j = 0; j <= NG; j++) begin
      prod = c_in;
      for (int m = 0; m < j; m++) prod = prod & pg[m];
      gc[j] = prod;
      for (int k = 0; k < j; k++) begin
        prod = gg[k];
        for (int m = k + 1; m < j; m++) prod = prod & pg[m];
        gc[j] = gc[j] | prod;
      end
    end
  end
  always_comb begin
    blk_g = 1'b0;
    bprod = 1'b0;
    for (int k = 0; k < NG; k++) begin
      bprod = gg[k];
      for (int m = k + 1; m < NG; m++) bprod = bprod & pg[m];
      blk_g = blk_g | bprod;
    end
  end
  always_comb begin
    out_valid_d = in_valid;
    s_d         = in_valid ? p ^ c  : s_q;
    c_out_d     = in_valid ? gc[NG] : c_out_q;
    p_out_d     = in_valid ? &pg    : p_out_q;
    g_out_d     = in_valid ? blk_g  : g_out_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_out_q     <= 1'b0;
      p_out_q     <= 1'b0;
      g_out_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      p_out_q     <= p_out_d;
      g_out_q     <= g_out_d;
    end
  end
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign p_out     = p_out_q;
  assign g_out     = g_out_q;
endmodule

// File: tb/tb_carry_lookahead_adder.sv
// tb_carry_lookahead_adder: table-driven bench for 4-bit and 16-bit adder instances
module tb_carry_lookahead_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v4 = 1'b0, v16 = 1'b0, c4 = 1'b0, c16 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic ov4, co4, po4, go4, ov16, co16, po16, go16;
  int errors = 0, checks = 0;
  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic        co, po, go;
  } vec_t;
  vec_t t4[9];
  vec_t t16[5];
  always #5 clk = ~clk;
  carry_lookahead_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c_in(c4),
    .out_valid(ov4), .s(s4), .c_out(co4), .p_out(po4), .g_out(go4)
  );
  carry_lookahead_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .c_in(c16),
    .out_valid(ov16), .s(s16), .c_out(co16), .p_out(po16), .g_out(go16)
  );
  task automatic chk(input string n, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {ov,co,po,go,s}=%h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [19:0] pk(input logic ov, co, po, go, input logic [15:0] sv);
    return {ov, co, po, go, sv};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [16:0] sum;
    t4[0] = '{16'hF, 16'h1, 1'b1, 16'h1, 1'b1, 1'b0, 1'b1};
    t4[1] = '{16'h6, 16'h5, 1'b0, 16'hB, 1'b0, 1'b0, 1'b0};
    t4[2] = '{16'h4, 16'h3, 1'b1, 16'h8, 1'b0, 1'b0, 1'b0};
    t4[3] = '{16'h9, 16'h5, 1'b1, 16'hF, 1'b0, 1'b0, 1'b0};
    t4[4] = '{16'hF, 16'hF, 1'b1, 16'hF, 1'b1, 1'b0, 1'b1};
    t4[5] = '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
    t4[6] = '{16'hA, 16'h5, 1'b0, 16'hF, 1'b0, 1'b1, 1'b0};
    t4[7] = '{16'hA, 16'h5, 1'b1, 16'h0, 1'b1, 1'b1, 1'b0};
    t4[8] = '{16'h8, 16'h8, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1};
    t16[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    t16[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    t16[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    t16[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1};
    t16[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    step();
    step();
    chk("reset", pk(ov4, co4, po4, go4, {12'h0, s4}), 20'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a4 = t4[i].a[3:0]; b4 = t4[i].b[3:0]; c4 = t4[i].ci; v4 = 1'b1;
      step();
      chk($sformatf("vec4_%0d", i), pk(ov4, co4, po4, go4, {12'h0, s4}),
          pk(1'b1, t4[i].co, t4[i].po, t4[i].go, t4[i].s));
    end
    v4 = 1'b0; a4 = 4'h3; b4 = 4'h7; c4 = 1'b1;
    step();
    chk("idle_hold", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0));
    a4 = 4'hC; b4 = 4'h1;
    step();
    chk("idle_hold2", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0));
    a4 = 4'h9; b4 = 4'h5; c4 = 1'b1; v4 = 1'b1;
    step();
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    chk("pipe_a", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'hF));
    step();
    v4 = 1'b0;
    chk("pipe_b", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b1, 1'b1, 1'b0, 1'b1, 16'hF));
    step();
    chk("pipe_idle", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b0, 1'b1, 1'b0, 1'b1, 16'hF));
    rst_n = 1'b0; v4 = 1'b1; a4 = 4'h6; b4 = 4'h6; c4 = 1'b0;
    #2;
    chk("rst_no_edge", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b0, 1'b1, 1'b0, 1'b1, 16'hF));
    step();
    chk("rst_midstream", pk(ov4, co4, po4, go4, {12'h0, s4}), 20'h0);
    rst_n = 1'b1; a4 = 4'h7; b4 = 4'h2; c4 = 1'b0;
    step();
    chk("post_rst", pk(ov4, co4, po4, go4, {12'h0, s4}), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'h9));
    v4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a16 = t16[i].a; b16 = t16[i].b; c16 = t16[i].ci; v16 = 1'b1;
      step();
      chk($sformatf("vec16_%0d", i), pk(ov16, co16, po16, go16, s16),
          pk(1'b1, t16[i].co, t16[i].po, t16[i].go, t16[i].s));
    end
    for (int i = 0; i < 10000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      if (i % 7 == 0) b16 = ~a16;
      sum = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
      step();
      chk($sformatf("rand16_%0d", i), pk(ov16, co16, po16, go16, s16),
          pk(1'b1, sum[16], &(a16 ^ b16), ({1'b0, a16} + {1'b0, b16}) >> 16, sum[15:0]));
    end
    v16 = 1'b0;
    step();
    chk("idle16", {19'h0, ov16}, 20'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
